uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Packet-level round-robin arbiter that shares one UART TX byte stream between N_SRC byte-stream requesters.
//   Sits directly in front of the UART transmitter: its master port drives the transmitter's tvalid/tdata/tkeep/tlast input.
//   A grant is held for a whole packet, ending on the tlast beat, so bytes from different sources never interleave on the line.
// PARAMETERS
//   N_SRC     4       number of requesters, legal range 2..8
//   HDR_BASE  8'hA0   header byte base, used only with UART_TX_ARB_HDR_EN; low 3 bits must be 0
// PORTS
//   clk         input   1          single clock, all logic posedge
//   rstn        input   1          asynchronous active-low reset
//   i_tvalid    input   N_SRC      per-source valid, bit k = source k
//   i_tdata     input   8*N_SRC    per-source byte, source k at [8k+7:8k]
//   i_tkeep     input   N_SRC      per-source keep
//   i_tlast     input   N_SRC      per-source end-of-packet
//   o_tready    output  N_SRC      per-source ready
//   o_tvalid    output  1          to UART TX
//   o_tdata     output  8          to UART TX
//   o_tkeep     output  1          to UART TX
//   o_tlast     output  1          to UART TX
//   i_tready    input   1          from UART TX
//   o_grant_id  output  3          index of the granted source, valid while o_busy=1
//   o_busy      output  1          1 while a packet (or its header) is in progress
// BEHAVIOUR
//   Reset values: state=IDLE, o_tvalid=0, o_tready=0, o_busy=0, o_grant_id=0, last_grant=N_SRC-1 (source 0 wins first).
//   FSM:
//     IDLE  no grant, all o_tready=0, o_tvalid=0.
//           If any i_tvalid is set, pick the first set bit searching upward from last_grant+1, mod N_SRC.
//           Register it into o_grant_id, then go to PASS (or HDR with the macro). Arbitration costs 1 cycle.
//     PASS  Combinational pass-through of granted source g:
//           o_tvalid=i_tvalid[g], o_tdata/o_tkeep/o_tlast from source g, o_tready[g]=i_tready, all other o_tready=0.
//           A beat is accepted when i_tvalid[g] & i_tready.
//           An accepted beat with i_tlast[g]=1 moves to IDLE and sets last_grant<=g.
//           Otherwise stay in PASS, even if i_tvalid[g] drops; no timeout; other requests wait.
//   o_busy=1 in every state except IDLE.
//   o_tkeep is passed through unmodified, including tkeep=0 beats.
//   Back-to-back packets: minimum one IDLE cycle between the tlast beat and the next packet's first beat.
//   If the same source requests again and it is the only requester, it is re-granted.
//   Simultaneous requests are resolved by round-robin order only; no priority.
//   Sources whose valid is asserted while not granted see o_tready=0 and must hold data (AXI-stream rules).
//   Reset mid-packet: FSM returns to IDLE immediately and the partial packet is truncated.
//   Upstream sources are reset by the same rstn.
//   The rotation index wraps modulo N_SRC; unused upper grant bits read 0.
// CONFIGURATION
//   UART_TX_ARB_HDR_EN defined:
//     An extra state HDR sits between IDLE and PASS.
//     In HDR: o_tvalid=1, o_tdata=HDR_BASE|grant_id, o_tkeep=1, o_tlast=0, all o_tready=0.
//     On i_tready go to PASS; each packet is prefixed by exactly one source-ID byte.
//   UART_TX_ARB_HDR_EN undefined:
//     No HDR state, IDLE->PASS directly, HDR_BASE ignored, stream content is bit-identical to the sources.
// TESTING
//   1. Reset, then only src2 sends {0x11,0x22,0x33(last)} with i_tready=1.
//      -> o_tdata 0x11,0x22,0x33 on consecutive cycles; o_grant_id=2; o_busy falls after 0x33.
//   2. src0..3 all valid with 1-byte packets, held continuously.
//      -> grant order 0,1,2,3,0; exactly 1 beat per grant; never two o_tready bits set.
//   3. src1 sends a 4-byte packet; src0 asserts valid after beat 1.
//      -> src1's 4 bytes are contiguous, then src0 is granted; o_tready[0]=0 throughout.
//   4. i_tready held 0 for 500 cycles mid-packet.
//      -> o_tvalid, o_tdata and the grant are held stable; no beat lost or duplicated.
//   5. Assert rstn=0 at byte 2 of a 3-byte packet.
//      -> next cycle o_tvalid=0, o_busy=0, o_grant_id=0; next grant goes to the lowest valid source.
//   6. With UART_TX_ARB_HDR_EN and HDR_BASE=0xA0, src3 sends {0x55(last)}.
//      -> o_tdata 0xA3 then 0x55; o_tlast only on 0x55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART TX byte stream between N_SRC sources.
// Define UART_TX_ARB_HDR_EN to prefix every packet with one HDR_BASE|source-ID byte.
module uart_tx_arbiter #(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] HDR_BASE = 8'hA0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_SRC-1:0]   i_tvalid,
    input  logic [8*N_SRC-1:0] i_tdata,
    input  logic [N_SRC-1:0]   i_tkeep,
    input  logic [N_SRC-1:0]   i_tlast,
    output logic [N_SRC-1:0]   o_tready,
    output logic               o_tvalid,
    output logic [7:0]         o_tdata,
    output logic               o_tkeep,
    output logic               o_tlast,
    input  logic               i_tready,
    output logic [2:0]         o_grant_id,
    output logic               o_busy
);
    localparam int GW = $clog2(N_SRC);

`ifdef UART_TX_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE, PASS, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, PASS} state_t;
`endif

    state_t                 r_state;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_last;
    logic [GW-1:0]          w_pick;
    logic [GW-1:0]          w_idx;
    logic [N_SRC-1:0][7:0]  w_bytes;
    logic                   w_pass;
    logic                   w_hdr;
    logic                   w_beat;

    // Scan downward so the last hit is the first requester above r_last.
    always_comb begin
        w_pick = r_last;
        w_idx  = r_last;
        for (int i = N_SRC; i >= 1; i--) begin
            w_idx = GW'((int'(r_last) + i) % N_SRC);
            if (i_tvalid[w_idx]) w_pick = w_idx;
        end
    end

    assign w_bytes = i_tdata;
    assign w_pass  = r_state == PASS;
`ifdef UART_TX_ARB_HDR_EN
    assign w_hdr   = r_state == HDR;
`else
    assign w_hdr   = 1'b0;
`endif
    assign w_beat     = w_pass & i_tvalid[r_grant] & i_tready;
    assign o_tvalid   = w_pass ? i_tvalid[r_grant] : w_hdr;
    assign o_tdata    = w_pass ? w_bytes[r_grant] : (HDR_BASE | 8'(r_grant));
    assign o_tkeep    = w_pass ? i_tkeep[r_grant] : w_hdr;
    assign o_tlast    = w_pass & i_tlast[r_grant];
    assign o_tready   = w_pass ? (N_SRC'(i_tready) << r_grant) : '0;
    assign o_busy     = r_state != IDLE;
    assign o_grant_id = 3'(r_grant);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(N_SRC - 1);
        end else begin
            case (r_state)
                IDLE: if (|i_tvalid) begin
                    r_grant <= w_pick;
`ifdef UART_TX_ARB_HDR_EN
                    r_state <= HDR;
`else
                    r_state <= PASS;
`endif
                end
`ifdef UART_TX_ARB_HDR_EN
                HDR: if (i_tready) r_state <= PASS;
`endif
                PASS: if (w_beat & i_tlast[r_grant]) begin
                    r_state <= IDLE;
                    r_last  <= r_grant;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
